// File: rtl/ctrl_module.sv
// Multi-cycle fetch/decode/execute control sequencer for the mpp accumulator CPU.
// Latency: control word is a combinational decode of registered state/IR; no input-to-output path.
// Backpressure: none; sequencer free-runs one state per clock and parks in HALT until reset.
module ctrl_module (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  instruction,
    output logic [28:0] ctrl_signals
);

    localparam int PC_INC      = 0;
    localparam int PC_LOAD     = 1;
    localparam int IR_LOAD     = 2;
    localparam int MAR_FROM_PC = 3;
    localparam int MAR_FROM_IR = 4;
    localparam int MEM_RD      = 5;
    localparam int MEM_WR      = 6;
    localparam int ACC_LOAD    = 7;
    localparam int ACC_FROM_ALU= 8;
    localparam int ALU_LSB     = 9;
    localparam int B_LOAD      = 12;
    localparam int FLAGS_LOAD  = 13;
    localparam int ACC_TO_BUS  = 14;
    localparam int IN_TO_ACC   = 17;
    localparam int OUT_LOAD    = 18;
    localparam int SP_INC      = 19;
    localparam int SP_DEC      = 20;
    localparam int STACK_WR    = 21;
    localparam int STACK_RD    = 22;
    localparam int CARRY_CLEAR = 23;
    localparam int CARRY_SET   = 24;
    localparam int COND_Z      = 25;
    localparam int COND_C      = 26;
    localparam int FETCH_CYCLE = 27;
    localparam int HALT_BIT    = 28;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EX1,
        S_EX2,
        S_EX3,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  ir;
    logic [3:0]  opcode;
    logic [3:0]  operand;
    logic [3:0]  alu_idx;
    logic [1:0]  n_steps;
    logic        is_hlt;
    logic [28:0] word;

    assign opcode  = ir[7:4];
    assign operand = ir[3:0];
    assign alu_idx = opcode - 4'd3;
    assign is_hlt  = (opcode == 4'hF) && (operand == 4'h0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ir    <= 8'h00;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE)
                ir <= instruction;
        end
    end

    // Number of execute states the latched opcode needs.
    always_comb begin
        n_steps = 2'd1;
        case (opcode)
            4'h1, 4'h2:                   n_steps = 2'd2;
            4'h3, 4'h4, 4'h5, 4'h6, 4'h7: n_steps = 2'd3;
            4'hF: if (operand == 4'h1 || operand == 4'h2) n_steps = 2'd2;
            default:                      n_steps = 2'd1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EX1;
            S_EX1: begin
                if (is_hlt)
                    state_nxt = S_HALT;
                else if (n_steps >= 2'd2)
                    state_nxt = S_EX2;
                else
                    state_nxt = S_FETCH;
            end
            S_EX2:    state_nxt = (n_steps == 2'd3) ? S_EX3 : S_FETCH;
            S_EX3:    state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        word = '0;
        case (state)
            S_FETCH: begin
                word[MAR_FROM_PC] = 1'b1;
                word[MEM_RD]      = 1'b1;
                word[FETCH_CYCLE] = 1'b1;
            end
            S_DECODE: begin
                word[PC_INC]  = 1'b1;
                word[IR_LOAD] = 1'b1;
            end
            S_EX1: begin
                case (opcode)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7:
                        word[MAR_FROM_IR] = 1'b1;
                    4'h8, 4'h9: begin
                        word[ACC_LOAD]     = 1'b1;
                        word[ACC_FROM_ALU] = 1'b1;
                        word[FLAGS_LOAD]   = 1'b1;
                        if (opcode == 4'h8)
                            word[ALU_LSB +: 3] = 3'b101;
                        else
                            word[ALU_LSB +: 3] = operand[0] ? 3'b111 : 3'b110;
                    end
                    4'hA: begin
                        word[IN_TO_ACC]  = 1'b1;
                        word[ACC_LOAD]   = 1'b1;
                        word[FLAGS_LOAD] = 1'b1;
                    end
                    4'hB: begin
                        word[OUT_LOAD]   = 1'b1;
                        word[ACC_TO_BUS] = 1'b1;
                    end
                    4'hC: word[PC_LOAD] = 1'b1;
                    4'hD: begin
                        word[PC_LOAD] = 1'b1;
                        word[COND_Z]  = 1'b1;
                    end
                    4'hE: begin
                        word[PC_LOAD] = 1'b1;
                        word[COND_C]  = 1'b1;
                    end
                    4'hF: begin
                        case (operand)
                            4'h0: word[HALT_BIT] = 1'b1;
                            4'h1: word[SP_DEC]   = 1'b1;
                            4'h2: begin
                                word[STACK_RD] = 1'b1;
                                word[ACC_LOAD] = 1'b1;
                            end
                            4'h3: word[CARRY_CLEAR] = 1'b1;
                            4'h4: word[CARRY_SET]   = 1'b1;
                            default: word = '0;
                        endcase
                    end
                    default: word = '0;
                endcase
            end
            S_EX2: begin
                case (opcode)
                    4'h1: begin
                        word[MEM_RD]   = 1'b1;
                        word[ACC_LOAD] = 1'b1;
                    end
                    4'h2: begin
                        word[ACC_TO_BUS] = 1'b1;
                        word[MEM_WR]     = 1'b1;
                    end
                    4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        word[MEM_RD] = 1'b1;
                        word[B_LOAD] = 1'b1;
                    end
                    4'hF: begin
                        if (operand == 4'h1) begin
                            word[ACC_TO_BUS] = 1'b1;
                            word[STACK_WR]   = 1'b1;
                        end else if (operand == 4'h2) begin
                            word[SP_INC] = 1'b1;
                        end
                    end
                    default: word = '0;
                endcase
            end
            S_EX3: begin
                word[ACC_LOAD]     = 1'b1;
                word[ACC_FROM_ALU] = 1'b1;
                word[FLAGS_LOAD]   = 1'b1;
                word[ALU_LSB +: 3] = alu_idx[2:0];
            end
            S_HALT:  word[HALT_BIT] = 1'b1;
            default: word = '0;
        endcase
    end

    assign ctrl_signals = word;

endmodule

// File: tb/tb_ctrl_module.sv
// Scoreboard bench for ctrl_module: expected control words are queued per instruction
// and compared one per clock, sampled 1 ns after each rising edge.
module tb_ctrl_module;

    logic        clk;
    logic        rst_n;
    logic [7:0]  instruction;
    logic [28:0] ctrl_signals;

    int n_cmp;
    int n_err;
    logic [28:0] exp_q[$];

    localparam logic [28:0] W_FETCH  = 29'h08000028;
    localparam logic [28:0] W_DECODE = 29'h00000005;
    localparam logic [28:0] W_HALT   = 29'h10000000;

    ctrl_module dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instruction  (instruction),
        .ctrl_signals (ctrl_signals)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [28:0] got, input logic [28:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [28:0] bits(input int a, input int b, input int c);
        logic [28:0] w;
        w = '0;
        if (a >= 0) w[a] = 1'b1;
        if (b >= 0) w[b] = 1'b1;
        if (c >= 0) w[c] = 1'b1;
        return w;
    endfunction

    // Execute-phase reference words derived from the control bit map.
    function automatic void push_exec(input logic [7:0] ins);
        logic [3:0]  op;
        logic [3:0]  sub;
        logic [28:0] alu_w;
        op  = ins[7:4];
        sub = ins[3:0];
        alu_w = bits(7, 8, 13);
        case (op)
            4'h0: exp_q.push_back(29'h0);
            4'h1: begin exp_q.push_back(bits(4, -1, -1)); exp_q.push_back(bits(5, 7, -1)); end
            4'h2: begin exp_q.push_back(bits(4, -1, -1)); exp_q.push_back(bits(14, 6, -1)); end
            4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                exp_q.push_back(bits(4, -1, -1));
                exp_q.push_back(bits(5, 12, -1));
                exp_q.push_back(alu_w | (29'(op - 4'd3) << 9));
            end
            4'h8: exp_q.push_back(alu_w | (29'd5 << 9));
            4'h9: exp_q.push_back(alu_w | ((sub[0] ? 29'd7 : 29'd6) << 9));
            4'hA: exp_q.push_back(bits(17, 7, 13));
            4'hB: exp_q.push_back(bits(18, 14, -1));
            4'hC: exp_q.push_back(bits(1, -1, -1));
            4'hD: exp_q.push_back(bits(1, 25, -1));
            4'hE: exp_q.push_back(bits(1, 26, -1));
            default: begin
                case (sub)
                    4'h0: exp_q.push_back(bits(28, -1, -1));
                    4'h1: begin exp_q.push_back(bits(20, -1, -1)); exp_q.push_back(bits(14, 21, -1)); end
                    4'h2: begin exp_q.push_back(bits(22, 7, -1)); exp_q.push_back(bits(19, -1, -1)); end
                    4'h3: exp_q.push_back(bits(23, -1, -1));
                    4'h4: exp_q.push_back(bits(24, -1, -1));
                    default: exp_q.push_back(29'h0);
                endcase
            end
        endcase
    endfunction

    task automatic pop_chk(input string tag);
        logic [28:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_underflow"}, ctrl_signals, 29'h1FFFFFFF ^ ctrl_signals);
        end else begin
            e = exp_q.pop_front();
            chk(tag, ctrl_signals, e);
        end
    endtask

    // One full instruction cycle; instruction is scrambled once IR has latched.
    task automatic run_instr(input logic [7:0] ins, input bit abort_after_ex1);
        int n;
        instruction = ins;
        exp_q.push_back(W_FETCH);
        exp_q.push_back(W_DECODE);
        push_exec(ins);
        n = exp_q.size();
        if (abort_after_ex1) n = 3;
        for (int i = 0; i < n; i++) begin
            pop_chk($sformatf("ins%02h_step%0d", ins, i));
            if (i >= 2) instruction = 8'($urandom);
        end
        exp_q.delete();
    endtask

    task automatic reset_pulse(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_in_reset"}, ctrl_signals, 29'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({tag, "_idle"}, ctrl_signals, 29'h0);
    endtask

    logic [7:0] prog [0:22];

    initial begin
        n_cmp = 0;
        n_err = 0;
        prog = '{8'h00, 8'h00, 8'h35, 8'h47, 8'h10, 8'h20, 8'h52, 8'h63, 8'h74,
                 8'h80, 8'h90, 8'h91, 8'hA0, 8'hB0, 8'hC3, 8'hD3, 8'hE3,
                 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF7, 8'hFF};
        rst_n = 1'b0;
        instruction = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", ctrl_signals, 29'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_after_release", ctrl_signals, 29'h0);

        foreach (prog[i]) run_instr(prog[i], 1'b0);

        // Abort an ALU-memory op after EX1; sequencer must restart at FETCH.
        run_instr(8'h35, 1'b1);
        reset_pulse("abort_add");
        run_instr(8'h47, 1'b0);

        run_instr(8'hF0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            instruction = 8'($urandom);
            @(posedge clk);
            #1;
            chk($sformatf("halt_hold%0d", i), ctrl_signals, W_HALT);
        end
        reset_pulse("halt_reset");
        run_instr(8'hB0, 1'b0);
        run_instr(8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
